// File: rtl/pipe_pkg.sv
// Shared widths, the register-zero constant and the forwarding select
// encoding used by the decode-to-execute operand stage.
package pipe_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CTRL_W = 8;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   // Operand source, highest priority first
   typedef enum logic [1:0] {
      FWD_EX  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2,
      FWD_RF  = 2'd3
   } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Priority operand selector for one source register: EX > MEM > WB > regfile.
// Register 0 is hard-wired to zero and never matches a forwarding bus.
module fwd_mux
   import pipe_pkg::*;
#(
   parameter int DW = pipe_pkg::DATA_W,
   parameter int AW = pipe_pkg::ADDR_W
) (
   input  logic [AW-1:0] src,
   input  logic          ex_en,
   input  logic [AW-1:0] ex_addr,
   input  logic [DW-1:0] ex_data,
   input  logic          mem_en,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   input  logic [DW-1:0] rf_data,
   output logic [DW-1:0] operand
);

   fwd_sel_e sel;
   logic     src_nz;

   assign src_nz = (src != REG_ZERO);

   // Pick the youngest in-flight producer of src
   always_comb begin
      sel = FWD_RF;
      if (src_nz && ex_en && (ex_addr == src))
         sel = FWD_EX;
      else if (src_nz && mem_en && (mem_addr == src))
         sel = FWD_MEM;
      else if (src_nz && wb_en && (wb_addr == src))
         sel = FWD_WB;
   end

   // Drive the operand; r0 reads as zero whatever the buses carry
   always_comb begin
      operand = rf_data;
      if (!src_nz) begin
         operand = '0;
      end else begin
         case (sel)
            FWD_EX:  operand = ex_data;
            FWD_MEM: operand = mem_data;
            FWD_WB:  operand = wb_data;
            default: operand = rf_data;
         endcase
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute operand stage: regfile read addressing, EX/MEM/WB
// forwarding, load-use stall/bubble, the ID/EX register and a saturating
// stall-cycle counter.
module id_ex_operand_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int ADDR_W = pipe_pkg::ADDR_W,
   parameter int CTRL_W = pipe_pkg::CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_wreg,
   input  logic [ADDR_W-1:0] id_waddr,
   input  logic              id_mem_read,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic [ADDR_W-1:0] raddr1,
   output logic [ADDR_W-1:0] raddr2,
   input  logic [DATA_W-1:0] rdata1,
   input  logic [DATA_W-1:0] rdata2,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              mem_wreg,
   input  logic [ADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              flush,
   output logic              stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_wreg,
   output logic [ADDR_W-1:0] ex_waddr,
   output logic              ex_mem_read,
   output logic [31:0]       stall_cnt
);

   logic              ex_fwd_en;
   logic              load_use;
   logic              bubble;
   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;

   assign raddr1 = id_rs;
   assign raddr2 = id_rt;

   // A load in EX has no result yet; it is picked up from MEM next cycle
   assign ex_fwd_en = ex_valid && ex_wreg && !ex_mem_read;

   assign load_use = id_valid && ex_valid && ex_mem_read && ex_wreg &&
                     (ex_waddr != REG_ZERO) &&
                     ((id_use_rs && (id_rs == ex_waddr)) ||
                      (id_use_rt && (id_rt == ex_waddr)));

   // A flushed instruction is discarded anyway, so it never needs to wait
   assign stall  = load_use && !flush && !rst;
   assign bubble = load_use || flush || !id_valid;

   fwd_mux #(.DW(DATA_W), .AW(ADDR_W)) u_fwd_rs (
      .src      (id_rs),
      .ex_en    (ex_fwd_en),
      .ex_addr  (ex_waddr),
      .ex_data  (ex_result),
      .mem_en   (mem_wreg),
      .mem_addr (mem_waddr),
      .mem_data (mem_wdata),
      .wb_en    (wb_we),
      .wb_addr  (wb_waddr),
      .wb_data  (wb_wdata),
      .rf_data  (rdata1),
      .operand  (fwd_a)
   );

   fwd_mux #(.DW(DATA_W), .AW(ADDR_W)) u_fwd_rt (
      .src      (id_rt),
      .ex_en    (ex_fwd_en),
      .ex_addr  (ex_waddr),
      .ex_data  (ex_result),
      .mem_en   (mem_wreg),
      .mem_addr (mem_waddr),
      .mem_data (mem_wdata),
      .wb_en    (wb_we),
      .wb_addr  (wb_waddr),
      .wb_data  (wb_wdata),
      .rf_data  (rdata2),
      .operand  (fwd_b)
   );

   // ID/EX register; a bubble only kills the flags that have side effects
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_a        <= '0;
         ex_b        <= '0;
         ex_imm      <= '0;
         ex_ctrl     <= '0;
         ex_wreg     <= 1'b0;
         ex_waddr    <= '0;
         ex_mem_read <= 1'b0;
      end else begin
         ex_a     <= fwd_a;
         ex_b     <= fwd_b;
         ex_imm   <= id_imm;
         ex_ctrl  <= id_ctrl;
         ex_waddr <= id_waddr;
         if (bubble) begin
            ex_valid    <= 1'b0;
            ex_wreg     <= 1'b0;
            ex_mem_read <= 1'b0;
         end else begin
            ex_valid    <= 1'b1;
            ex_wreg     <= id_wreg;
            ex_mem_read <= id_mem_read;
         end
      end
   end

   // Saturating count of stalled cycles for performance debug
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute operand stage of the static 5-stage pipeline.
- Drives the register file read addresses and takes its combinational read data.
- Resolves RAW hazards by forwarding from EX/MEM/WB, detects load-use hazards and generates stall plus bubble.
- Holds the ID/EX pipeline register that feeds the ALU; keeps a saturating stall-cycle counter for performance debug.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register address width
CTRL_W, 8, opaque ALU/control bundle width

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  ADDR_W  source register 1
id_rt  in  ADDR_W  source register 2
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_wreg  in  1  instruction writes a register
id_waddr  in  ADDR_W  destination register
id_mem_read  in  1  instruction is a load
id_imm  in  DATA_W  extended immediate
id_ctrl  in  CTRL_W  control bundle, passed through
raddr1  out  ADDR_W  regfile read address 1 (= id_rs)
raddr2  out  ADDR_W  regfile read address 2 (= id_rt)
rdata1  in  DATA_W  regfile read data 1
rdata2  in  DATA_W  regfile read data 2
ex_result  in  DATA_W  combinational ALU result of the instruction in EX
mem_wreg  in  1  MEM-stage instruction writes a register
mem_waddr  in  ADDR_W  MEM-stage destination
mem_wdata  in  DATA_W  MEM-stage final value (load data already merged)
wb_we  in  1  same net as regfile we
wb_waddr  in  ADDR_W  same net as regfile waddr
wb_wdata  in  DATA_W  same net as regfile wdata
flush  in  1  squash the ID instruction (taken branch/jump)
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  ID/EX register valid
ex_a  out  DATA_W  forwarded rs operand
ex_b  out  DATA_W  forwarded rt operand
ex_imm  out  DATA_W  registered immediate
ex_ctrl  out  CTRL_W  registered control
ex_wreg  out  1  registered write enable
ex_waddr  out  ADDR_W  registered destination
ex_mem_read  out  1  registered load flag
stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Reset (asynchronous): all ex_* outputs are 0, stall_cnt is 0. stall is combinational and is 0 while rst is high.
- Register 0 is never a forwarding target.
  - A source address of 0 yields operand 0 regardless of the forwarding buses.
- Forward match from stage S requires S write enable = 1, S address = source, and source != 0.
  - EX stage uses ex_valid && ex_wreg && !ex_mem_read.
- Forwarding priority: EX (ex_result) > MEM (mem_wdata) > WB (wb_wdata) > rdata.
  - The WB bypass is mandatory: the regfile writes on the clock edge, so its read data is stale in the cycle wb_we is asserted.
- Load-use hazard:
  - Condition: id_valid && ex_valid && ex_mem_read && ex_wreg && ex_waddr != 0 && ((id_use_rs && id_rs == ex_waddr) || (id_use_rt && id_rt == ex_waddr)).
  - Response: stall = 1 and the next ID/EX state is a bubble (ex_valid = 0, ex_wreg = 0, ex_mem_read = 0).
  - The stall lasts exactly 1 cycle. The next cycle the load sits in MEM and is forwarded from mem_wdata.
- flush has priority over stall:
  - stall = 0 and the next ID/EX state is a bubble.
- Normal update, on each rising edge when not stalling or flushing:
  - ex_* load the forwarded operands and the id_* fields.
  - ex_valid = id_valid.
  - ex_wreg = id_wreg && id_valid.
- id_valid = 0 produces a bubble and never asserts stall.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- stall_cnt increments by 1 on each edge where stall = 1 and saturates at 0xFFFF_FFFF.
- Reset asserted mid-stall clears everything immediately; the first edge after rst falls loads normally.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W, ADDR_W, CTRL_W
  - REG_ZERO = 5'd0
  - the forwarding-select encoding FWD_EX / FWD_MEM / FWD_WB / FWD_RF
- One sub-module, fwd_mux: pure combinational priority selector, instantiated twice (rs, rt).
- Hazard detection, the ID/EX register and the counter stay in the top module.

Test Plan:
- WB bypass: wb_we=1, wb_waddr=3, wb_wdata=0x0000_1234, rdata1=0, id_rs=3, id_use_rs=1 -> after the edge ex_a=0x0000_1234.
- Priority: EX writes r5 with ex_result=0xA, mem_waddr=5 with mem_wdata=0xB, wb_waddr=5 with wb_wdata=0xC, id_rt=5 -> ex_b=0xA. Drop EX -> 0xB. Drop MEM -> 0xC.
- r0 guard: mem_wreg=1, mem_waddr=0, mem_wdata=0xFF, id_rs=0 -> ex_a=0.
- Load-use: lw r2 in EX, then add r4,r2,r1 in ID -> stall=1 for one cycle, next ex_valid=0 and stall_cnt=1. Following edge: ex_a equals mem_wdata=0x55AA and ex_valid=1.
- Flush during load-use: same setup plus flush=1 -> stall=0, bubble inserted, stall_cnt unchanged.
- Reset mid-operation: assert rst between edges while stall=1 -> ex_valid, ex_a, ex_wreg and stall_cnt read 0 immediately, stall=0.
